// File: rtl/ps2_packet_ctrl_if.sv
// Byte-stream input and packet-output bundle for the PS/2 packet controller.
// No latency of its own; wires only.
// Byte side cannot be stalled; packet side uses valid/ready.
interface ps2_packet_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        pkt_ready;
  logic        pkt_valid;
  logic [23:0] pkt_data;
  logic        pkt_drop;
  logic        resync;
  logic [7:0]  drop_count;

  // Environment side: drives bytes and ready, observes packets and status.
  modport master (
    output in_valid, in_data, pkt_ready,
    input  pkt_valid, pkt_data, pkt_drop, resync, drop_count
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, pkt_ready,
    output pkt_valid, pkt_data, pkt_drop, resync, drop_count
  );
endinterface

// File: rtl/ps2_packet_ctrl.sv
// Assembles PS/2 mouse bytes into 3-byte packets with bit-3 framing and an inter-byte timeout.
// Latency: pkt_valid rises on the edge that samples byte 3; pulses are registered, one cycle late.
// Upstream never stalls; a finished packet arriving while the one-entry buffer is held is dropped and counted.
module ps2_packet_ctrl #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_packet_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  // Counter value in the last idle cycle before a partial packet is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [15:0] tmo_q, tmo_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [23:0] pkt_data_q, pkt_data_d;
  logic        pkt_drop_q, pkt_drop_d;
  logic        resync_q, resync_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        complete;

  // Assembler: framing on byte 1 bit 3, byte capture and inter-byte timeout.
  always_comb begin
    state_d  = state_q;
    byte1_d  = byte1_q;
    byte2_d  = byte2_q;
    tmo_d    = tmo_q;
    resync_d = 1'b0;
    complete = 1'b0;
    case (state_q)
      SYNC: begin
        tmo_d = 16'd0;
        if (bus.in_valid) begin
          if (bus.in_data[3]) begin
            byte1_d = bus.in_data;
            state_d = GOT1;
          end else begin
            resync_d = 1'b1;
          end
        end
      end
      GOT1: begin
        if (bus.in_valid) begin
          // A byte in the timeout cycle still counts; it wins over the timeout.
          byte2_d = bus.in_data;
          tmo_d   = 16'd0;
          state_d = GOT2;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d    = 16'd0;
          resync_d = 1'b1;
          state_d  = SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      GOT2: begin
        if (bus.in_valid) begin
          // Byte 3 is taken as-is; only byte 1 carries the framing bit.
          complete = 1'b1;
          tmo_d    = 16'd0;
          state_d  = SYNC;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d    = 16'd0;
          resync_d = 1'b1;
          state_d  = SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        tmo_d   = 16'd0;
        state_d = SYNC;
      end
    endcase
  end

  // One-entry output buffer: load on completion if free or being drained, else drop and count.
  always_comb begin
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    pkt_drop_d  = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    if (complete) begin
      if (!pkt_valid_q || bus.pkt_ready) begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = {byte1_q, byte2_q, bus.in_data};
      end else begin
        pkt_drop_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end else if (pkt_valid_q && bus.pkt_ready) begin
      pkt_valid_d = 1'b0;
    end
  end

  // State and output registers; a pending packet is simply lost on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      byte1_q     <= 8'h00;
      byte2_q     <= 8'h00;
      tmo_q       <= 16'd0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 24'h0;
      pkt_drop_q  <= 1'b0;
      resync_q    <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte1_q     <= byte1_d;
      byte2_q     <= byte2_d;
      tmo_q       <= tmo_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      pkt_drop_q  <= pkt_drop_d;
      resync_q    <= resync_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.pkt_data   = pkt_data_q;
  assign bus.pkt_drop   = pkt_drop_q;
  assign bus.resync     = resync_q;
  assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Bench for ps2_packet_ctrl: vector table, directed corner sequences, and randomized traffic.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// A packet-level reference model tracks every cycle and is compared alongside the fixed expectations.
module tb_ps2_packet_ctrl;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_packet_ctrl_if bus_if ();

  ps2_packet_ctrl #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: partial packet as a byte queue, idle cycle count, one-entry buffer.
  logic [7:0]  m_pq[$];
  int          m_idle = 0;
  logic        m_v = 1'b0;
  logic [23:0] m_d = 24'h0;
  logic        m_drop = 1'b0;
  logic        m_res = 1'b0;
  int          m_cnt = 0;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [23:0] edat;
    logic        edrop;
    logic        eres;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic rst, logic v, logic [7:0] d, logic rdy,
                              logic ev, logic [23:0] edat, logic edrop, logic eres, logic [7:0] ecnt);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.edat = edat; t.edrop = edrop; t.eres = eres; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    logic        done;
    logic [23:0] pkt;
    done = 1'b0;
    pkt = 24'h0;
    if (r) begin
      m_pq.delete();
      m_idle = 0; m_v = 1'b0; m_d = 24'h0; m_drop = 1'b0; m_res = 1'b0; m_cnt = 0;
      return;
    end
    m_drop = 1'b0;
    m_res  = 1'b0;
    if (v) begin
      m_idle = 0;
      if (m_pq.size() == 0 && !d[3]) begin
        m_res = 1'b1;
      end else begin
        m_pq.push_back(d);
        if (m_pq.size() == 3) begin
          pkt = {m_pq[0], m_pq[1], m_pq[2]};
          m_pq.delete();
          done = 1'b1;
        end
      end
    end else if (m_pq.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_pq.delete();
        m_idle = 0;
        m_res = 1'b1;
      end
    end
    if (done) begin
      if (!m_v || rdy) begin
        m_v = 1'b1;
        m_d = pkt;
      end else begin
        m_drop = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (m_v && rdy) begin
      m_v = 1'b0;
    end
  endtask

  task automatic cmp_model();
    chk("model pkt_valid", 32'(bus_if.pkt_valid), 32'(m_v));
    chk("model pkt_data", 32'(bus_if.pkt_data), 32'(m_d));
    chk("model pkt_drop", 32'(bus_if.pkt_drop), 32'(m_drop));
    chk("model resync", 32'(bus_if.resync), 32'(m_res));
    chk("model drop_count", 32'(bus_if.drop_count), 32'(m_cnt));
  endtask

  // One clock: drive on the falling edge, model the rising edge, check on the next falling edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    reset = r;
    bus_if.in_valid = v;
    bus_if.in_data = d;
    bus_if.pkt_ready = rdy;
    @(posedge clk);
    model_step(r, v, d, rdy);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, rdy);
  endtask

  // Overall time guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data = 8'h00;
    bus_if.pkt_ready = 1'b0;

    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 24'h000000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h08, 1, 0, 24'h000000, 0, 0, 0);
    tbl[2]  = mk(0, 1, 8'h12, 1, 0, 24'h000000, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'h34, 1, 1, 24'h081234, 0, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 0, 24'h081234, 0, 0, 0);
    tbl[5]  = mk(0, 1, 8'h12, 1, 0, 24'h081234, 0, 1, 0);
    tbl[6]  = mk(0, 1, 8'h34, 1, 0, 24'h081234, 0, 1, 0);
    tbl[7]  = mk(0, 1, 8'h09, 1, 0, 24'h081234, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'hAA, 1, 0, 24'h081234, 0, 0, 0);
    tbl[9]  = mk(0, 1, 8'hBB, 1, 1, 24'h09AABB, 0, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 0, 24'h09AABB, 0, 0, 0);
    tbl[11] = mk(0, 1, 8'h08, 0, 0, 24'h09AABB, 0, 0, 0);
    tbl[12] = mk(0, 1, 8'h01, 0, 0, 24'h09AABB, 0, 0, 0);
    tbl[13] = mk(0, 1, 8'h02, 0, 1, 24'h080102, 0, 0, 0);
    tbl[14] = mk(0, 1, 8'h08, 0, 1, 24'h080102, 0, 0, 0);
    tbl[15] = mk(0, 1, 8'h03, 0, 1, 24'h080102, 0, 0, 0);
    tbl[16] = mk(0, 1, 8'h04, 0, 1, 24'h080102, 1, 0, 1);
    tbl[17] = mk(0, 0, 8'h00, 0, 1, 24'h080102, 0, 0, 1);
    tbl[18] = mk(0, 0, 8'h00, 1, 0, 24'h080102, 0, 0, 1);

    @(negedge clk);

    // Vector table: reset, basic packet, misaligned start, backpressure with drop.
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d pkt_valid", i), 32'(bus_if.pkt_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d pkt_data", i), 32'(bus_if.pkt_data), 32'(tbl[i].edat));
      chk($sformatf("vec%0d pkt_drop", i), 32'(bus_if.pkt_drop), 32'(tbl[i].edrop));
      chk($sformatf("vec%0d resync", i), 32'(bus_if.resync), 32'(tbl[i].eres));
      chk($sformatf("vec%0d drop_count", i), 32'(bus_if.drop_count), 32'(tbl[i].ecnt));
    end

    // Timeout after exactly TMO idle cycles.
    cyc(1, 0, 8'h00, 1);
    cyc(0, 1, 8'h08, 1);
    idle(TMO - 1, 1'b1);
    chk("tmo no resync before limit", 32'(bus_if.resync), 32'd0);
    idle(1, 1'b1);
    chk("tmo resync at limit", 32'(bus_if.resync), 32'd1);
    cyc(0, 1, 8'h18, 1);
    chk("tmo resync one cycle", 32'(bus_if.resync), 32'd0);
    cyc(0, 1, 8'h01, 1);
    cyc(0, 1, 8'h02, 1);
    chk("tmo packet valid", 32'(bus_if.pkt_valid), 32'd1);
    chk("tmo packet data", 32'(bus_if.pkt_data), 32'h180102);

    // Byte in the timeout cycle wins.
    cyc(1, 0, 8'h00, 1);
    cyc(0, 1, 8'h08, 1);
    idle(TMO - 1, 1'b1);
    cyc(0, 1, 8'h18, 1);
    chk("tmo race no resync", 32'(bus_if.resync), 32'd0);
    cyc(0, 1, 8'h01, 1);
    chk("tmo race resync", 32'(bus_if.resync), 32'd0);
    chk("tmo race data", 32'(bus_if.pkt_data), 32'h081801);
    chk("tmo race valid", 32'(bus_if.pkt_valid), 32'd1);

    // Accept and load in the same cycle.
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h08, 0);
    cyc(0, 1, 8'h01, 0);
    cyc(0, 1, 8'h02, 0);
    cyc(0, 1, 8'h08, 0);
    cyc(0, 1, 8'h05, 0);
    cyc(0, 1, 8'h06, 1);
    chk("same-cycle valid", 32'(bus_if.pkt_valid), 32'd1);
    chk("same-cycle data", 32'(bus_if.pkt_data), 32'h080506);
    chk("same-cycle no drop", 32'(bus_if.pkt_drop), 32'd0);
    chk("same-cycle count", 32'(bus_if.drop_count), 32'd0);
    idle(1, 1'b1);
    chk("same-cycle drained", 32'(bus_if.pkt_valid), 32'd0);

    // Reset with a pending packet, then reset mid-packet.
    cyc(0, 1, 8'h08, 0);
    cyc(0, 1, 8'h0A, 0);
    cyc(0, 1, 8'h0B, 0);
    cyc(1, 0, 8'h00, 0);
    chk("reset pending valid", 32'(bus_if.pkt_valid), 32'd0);
    chk("reset pending data", 32'(bus_if.pkt_data), 32'h0);
    chk("reset pending drop", 32'(bus_if.pkt_drop), 32'd0);
    cyc(0, 1, 8'h08, 1);
    cyc(0, 1, 8'h12, 1);
    cyc(1, 0, 8'h00, 1);
    chk("reset mid resync", 32'(bus_if.resync), 32'd0);
    cyc(0, 1, 8'h55, 1);
    chk("post-reset 55 resync", 32'(bus_if.resync), 32'd1);
    cyc(0, 1, 8'h08, 1);
    cyc(0, 1, 8'h01, 1);
    cyc(0, 1, 8'h02, 1);
    chk("post-reset valid", 32'(bus_if.pkt_valid), 32'd1);
    chk("post-reset data", 32'(bus_if.pkt_data), 32'h080102);

    // Drop counter saturation under held backpressure.
    cyc(1, 0, 8'h00, 0);
    for (int p = 0; p < 301; p++) begin
      cyc(0, 1, 8'h08, 0);
      cyc(0, 1, 8'h01, 0);
      cyc(0, 1, 8'h02, 0);
      if (p == 255) chk("sat count at 255 drops", 32'(bus_if.drop_count), 32'd255);
    end
    chk("sat count", 32'(bus_if.drop_count), 32'd255);
    chk("sat held data", 32'(bus_if.pkt_data), 32'h080102);
    chk("sat held valid", 32'(bus_if.pkt_valid), 32'd1);

    // Randomized traffic against the model.
    cyc(1, 0, 8'h00, 1);
    begin
      int burst;
      logic v;
      logic rdy;
      logic [7:0] d;
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
        if (burst > 0) begin
          burst--;
          v = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          burst = $urandom_range(5, 12);
          v = 1'b0;
        end else begin
          v = ($urandom_range(0, 9) < 6);
        end
        d = 8'($urandom);
        if ($urandom_range(0, 9) < 7) d[3] = 1'b1;
        rdy = ($urandom_range(0, 9) < 6);
        cyc(($urandom_range(0, 299) == 0), v, d, rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_packet_ctrl.md
# ps2_packet_ctrl

Sequences the PS/2 mouse byte stream into complete 3-byte packets and hands them to the host logic over a valid/ready interface. Sits between the PS/2 serial byte receiver (one-cycle byte strobes, no backpressure) and the consumer. It performs frame synchronisation on byte 1 bit 3 and recovers from stalled packets with an inter-byte timeout. It buffers one finished packet, and it counts packets lost to consumer backpressure.

## Interface
- TIMEOUT, 1000: cycles without a byte, mid-packet, before the assembler abandons the packet; legal range 2..65535.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- in_data  in  8  received byte.
- pkt_ready  in  1  consumer accepts pkt_data when high with pkt_valid.
- pkt_valid  out  1  pkt_data holds an unconsumed packet.
- pkt_data  out  24  {byte1, byte2, byte3}; byte1 is in [23:16].
- pkt_drop  out  1  one-cycle pulse: a completed packet was discarded.
- resync  out  1  one-cycle pulse: a byte was discarded in SYNC, or a timeout fired.
- drop_count  out  8  number of dropped packets; saturates at 255.

## Operation
- The assembler FSM has 3 states: SYNC, GOT1, GOT2.
- SYNC:
  - in_valid with in_data[3]=1: latch byte1 and go to GOT1.
  - in_valid with in_data[3]=0: discard the byte, pulse resync, stay in SYNC.
- GOT1: in_valid latches byte2 and goes to GOT2.
- GOT2: in_valid latches byte3 (bit 3 is not checked), completes the packet, and goes to SYNC.
  - The next packet's first byte must again satisfy bit3=1.
- Timeout counter (16 bits):
  - Cleared on every accepted byte and whenever the FSM is in SYNC.
  - Increments each cycle in GOT1/GOT2 while in_valid=0.
  - When it equals TIMEOUT-1 and in_valid=0, the FSM goes to SYNC, pulses resync, and discards the partial bytes.
- Timeout and byte arriving in the same cycle: the byte wins; it is accepted normally and no resync is pulsed.
- Output buffer, one entry. On packet completion:
  - If pkt_valid=0, or pkt_valid=1 and pkt_ready=1 in that cycle: load pkt_data and set pkt_valid.
  - Otherwise (pkt_valid=1 and pkt_ready=0): keep the old packet, discard the new one, pulse pkt_drop, and increment drop_count (saturating at 255).
- pkt_valid clears after a cycle with pkt_valid and pkt_ready both high, unless a new packet loads in that same cycle.
- pkt_data is stable while pkt_valid=1 and pkt_ready=0.
- Upstream is never stalled; every in_valid byte is either consumed or discarded.

## Timing
- Reset values:
  - State SYNC; timeout counter 0.
  - pkt_valid 0, pkt_data 24'h0, pkt_drop 0, resync 0, drop_count 0.
- Reset mid-packet or with a packet pending: all of the above values are restored on the next edge, and the pending packet is lost without a pkt_drop pulse.
- Latency: pkt_valid rises on the clock edge that samples the in_valid of byte3, so it is visible the cycle after the third strobe.
- pkt_drop and resync assert for exactly one cycle, registered, in the cycle after the causing event.
- Back-to-back in_valid on consecutive cycles is supported; a packet may therefore complete every 3 cycles.
- Timeout fires after exactly TIMEOUT consecutive byte-less cycles following the last accepted byte.
  - resync is high in the cycle after the edge that returns the FSM to SYNC.
  - A byte strobed in that same cycle is treated as a SYNC byte.

## Test plan
- Sync and basic packet:
  - Stimulus: bytes 8'h08, 8'h12, 8'h34 with pkt_ready=1.
  - Response: pkt_valid for one cycle, pkt_data=24'h081234; no resync.
- Resync on misaligned start:
  - Stimulus: bytes 8'h12, 8'h34, then 8'h09, 8'hAA, 8'hBB.
  - Response: two resync pulses, then pkt_data=24'h09AABB.
- Timeout:
  - Stimulus: TIMEOUT=8; byte 8'h08, then 8 idle cycles, then 8'h18, 8'h01, 8'h02.
  - Response: one resync pulse; packet 24'h180102. With 7 idle cycles instead, no resync occurs and the 3-byte packet is 24'h081801.
- Backpressure and drop:
  - Stimulus: pkt_ready=0; packets 24'h080102 and 24'h080304.
  - Response: pkt_data stays 24'h080102; one pkt_drop pulse; drop_count=1.
  - Then raising pkt_ready clears pkt_valid after one cycle.
- Accept and load in the same cycle:
  - Stimulus: the third byte of a new packet arrives in the cycle where pkt_valid=1 and pkt_ready=1.
  - Response: the new packet is loaded, pkt_valid stays high, and there is no drop.
- Reset mid-packet and counter saturation:
  - Stimulus: reset after byte2, then bytes 8'h55, 8'h08, 8'h01, 8'h02.
  - Response: one resync pulse (for 8'h55), then packet 24'h080102.
  - Stimulus: 300 drops under held pkt_ready=0.
  - Response: drop_count=255.
